// File: rtl/idu_dispatch_pkg.sv
// Shared definitions for the instruction decode/dispatch front end:
// opcode classes, instruction-word field positions, FSM encoding and
// the decoded-entry layout carried through the dispatch queue.
package idu_dispatch_pkg;

    localparam int QDEPTH = 2;

    // Opcode classes
    localparam logic [7:0] OP_HALT      = 8'h00;
    localparam logic [7:0] OP_NOP       = 8'h01;
    localparam logic [7:0] OP_MAX_LEGAL = 8'h0F;

    // Instruction word field positions (LSB of each field)
    localparam int OP_LSB   = 56;
    localparam int DST_LSB  = 40;
    localparam int SRC0_LSB = 24;
    localparam int SRC1_LSB = 8;
    localparam int LEN_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } idu_state_t;

    typedef struct packed {
        logic [7:0]  op;
        logic [15:0] dst;
        logic [15:0] src0;
        logic [15:0] src1;
        logic [7:0]  len;
    } idu_entry_t;

    localparam int ENTRY_W = $bits(idu_entry_t);

    function automatic idu_entry_t decode_ins(input logic [63:0] ins);
        idu_entry_t e;
        e.op   = ins[OP_LSB   +: 8];
        e.dst  = ins[DST_LSB  +: 16];
        e.src0 = ins[SRC0_LSB +: 16];
        e.src1 = ins[SRC1_LSB +: 16];
        e.len  = ins[LEN_LSB  +: 8];
        return e;
    endfunction

    function automatic logic is_dispatch(input logic [7:0] op);
        return (op > OP_NOP) && (op <= OP_MAX_LEGAL);
    endfunction

    function automatic logic is_illegal(input logic [7:0] op);
        return op > OP_MAX_LEGAL;
    endfunction

endpackage

// File: rtl/idu_ins_fifo.sv
// Two-entry synchronous FIFO built from a 1-bit read pointer, a 1-bit
// write pointer and a 2-bit occupancy count. Flush empties it in one
// cycle and wins over push/pop. The head reads as zero while empty.
// The default width covers the operand/length fields; the top level
// widens it so each entry also carries the opcode.
module idu_ins_fifo #(
    parameter int WIDTH = 56
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == 2'd2);
    assign empty   = (cnt == 2'd0);
    assign count   = cnt;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Pointer, count and storage update; pointers wrap modulo 2
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt    <= 2'd0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/idu_dispatch.sv
// Decode/dispatch front end. Consumes 64-bit words from fetch, decodes
// the fields, filters NOP/illegal/HALT, queues dispatchable entries in a
// two-entry FIFO and presents the head to the execution unit.
//
// Handshakes: a transfer happens on a cycle where the producer's valid
// and the consumer's ready are both high. Valid never depends on ready.
// Fetch side: accept = ifu_idu_vld & idu_ifu_rdy; idu_ifu_wfi low tells
// fetch to drop its valid next cycle. Execute side: dequeue =
// idu_exu_vld & exu_idu_rdy; head fields hold while valid and not taken.
module idu_dispatch
    import idu_dispatch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_vld,
    input  logic        ifu_idu_vld,
    input  logic [63:0] ifu_idu_ins,
    output logic        idu_ifu_rdy,
    output logic        idu_ifu_wfi,
    output logic        idu_exu_vld,
    output logic [7:0]  idu_exu_op,
    output logic [15:0] idu_exu_dst,
    output logic [15:0] idu_exu_src0,
    output logic [15:0] idu_exu_src1,
    output logic [7:0]  idu_exu_len,
    input  logic        exu_idu_rdy,
    output logic        idu_busy,
    output logic        idu_done,
    output logic        idu_err,
    output logic [1:0]  dbg_state
);

    idu_state_t state;
    idu_state_t state_next;
    idu_entry_t dec;
    idu_entry_t head;

    logic       accept;
    logic       halt_acc;
    logic       push;
    logic       ill_acc;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic [1:0] fifo_count;
    logic [1:0] count_next;
    logic       busy_d;
    logic       done_d;
    logic       busy_q;
    logic       done_q;
    logic       err_q;

    assign dec      = decode_ins(ifu_idu_ins);
    assign idu_ifu_rdy = (state == ST_RUN) & ~fifo_full;
    assign accept   = ifu_idu_vld & idu_ifu_rdy;
    assign halt_acc = accept & (dec.op == OP_HALT);
    assign push     = accept & is_dispatch(dec.op);
    assign ill_acc  = accept & is_illegal(dec.op);
    assign pop      = idu_exu_vld & exu_idu_rdy;

    // Occupancy after this edge; start_vld flushes regardless of traffic
    assign count_next = start_vld ? 2'd0
                                  : fifo_count + {1'b0, push} - {1'b0, pop};

    idu_ins_fifo #(
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (start_vld),
        .push  (push),
        .pop   (pop),
        .din   (dec),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign idu_exu_vld  = ~fifo_empty;
    assign idu_exu_op   = head.op;
    assign idu_exu_dst  = head.dst;
    assign idu_exu_src0 = head.src0;
    assign idu_exu_src1 = head.src1;
    assign idu_exu_len  = head.len;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state; start_vld outranks every other event
    always_comb begin
        state_next = state;
        if (start_vld) begin
            state_next = ST_RUN;
        end else begin
            case (state)
                ST_IDLE:  state_next = ST_IDLE;
                ST_RUN:   if (halt_acc) state_next = ST_DRAIN;
                ST_DRAIN: if (fifo_empty) state_next = ST_IDLE;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: fetch keep-alive and the pre-register busy/done terms
    always_comb begin
        idu_ifu_wfi = (state == ST_RUN) & ~halt_acc;
        busy_d      = (state_next != ST_IDLE);
        // Done lands in the one DRAIN cycle that sees an empty queue
        done_d      = (state_next == ST_DRAIN) & (count_next == 2'd0);
    end

    // Registered status flags; err is sticky until start_vld
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            if (start_vld) begin
                err_q <= 1'b0;
            end else if (ill_acc) begin
                err_q <= 1'b1;
            end
        end
    end

    assign idu_busy  = busy_q;
    assign idu_done  = done_q;
    assign idu_err   = err_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_idu_dispatch.sv
// Directed, table-driven bench for idu_dispatch. Each record gives one
// cycle of inputs and the outputs expected in that cycle; inputs are
// driven on the falling edge and outputs checked 1ns later.
module tb_idu_dispatch;

    logic        clk;
    logic        rst;
    logic        start_vld;
    logic        ifu_idu_vld;
    logic [63:0] ifu_idu_ins;
    logic        idu_ifu_rdy;
    logic        idu_ifu_wfi;
    logic        idu_exu_vld;
    logic [7:0]  idu_exu_op;
    logic [15:0] idu_exu_dst;
    logic [15:0] idu_exu_src0;
    logic [15:0] idu_exu_src1;
    logic [7:0]  idu_exu_len;
    logic        exu_idu_rdy;
    logic        idu_busy;
    logic        idu_done;
    logic        idu_err;
    logic [1:0]  dbg_state;

    int n_vec;
    int n_bad;

    idu_dispatch dut (
        .clk          (clk),
        .rst          (rst),
        .start_vld    (start_vld),
        .ifu_idu_vld  (ifu_idu_vld),
        .ifu_idu_ins  (ifu_idu_ins),
        .idu_ifu_rdy  (idu_ifu_rdy),
        .idu_ifu_wfi  (idu_ifu_wfi),
        .idu_exu_vld  (idu_exu_vld),
        .idu_exu_op   (idu_exu_op),
        .idu_exu_dst  (idu_exu_dst),
        .idu_exu_src0 (idu_exu_src0),
        .idu_exu_src1 (idu_exu_src1),
        .idu_exu_len  (idu_exu_len),
        .exu_idu_rdy  (exu_idu_rdy),
        .idu_busy     (idu_busy),
        .idu_done     (idu_done),
        .idu_err      (idu_err),
        .dbg_state    (dbg_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        vld;
        logic [63:0] ins;
        logic        xrdy;
        logic        e_rdy;
        logic        e_wfi;
        logic        e_xvld;
        logic [63:0] e_head;
        logic        e_busy;
        logic        e_done;
        logic        e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [63:0] mkins(input logic [7:0] op, input logic [7:0] t);
        return {op, 8'hd0, t, 8'h50, t, 8'h60, t, t};
    endfunction

    function automatic vec_t mkv(input logic st, input logic vld, input logic [63:0] ins,
                                 input logic xrdy, input logic e_rdy, input logic e_wfi,
                                 input logic e_xvld, input logic [63:0] e_head,
                                 input logic e_busy, input logic e_done, input logic e_err);
        vec_t v;
        v.st = st; v.vld = vld; v.ins = ins; v.xrdy = xrdy;
        v.e_rdy = e_rdy; v.e_wfi = e_wfi; v.e_xvld = e_xvld; v.e_head = e_head;
        v.e_busy = e_busy; v.e_done = e_done; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] head_now();
        return {idu_exu_op, idu_exu_dst, idu_exu_src0, idu_exu_src1, idu_exu_len};
    endfunction

    task automatic chk_all_zero(input string tag);
        n_vec++;
        chk({tag, " rdy"},   64'(idu_ifu_rdy), 64'd0);
        chk({tag, " wfi"},   64'(idu_ifu_wfi), 64'd0);
        chk({tag, " xvld"},  64'(idu_exu_vld), 64'd0);
        chk({tag, " head"},  head_now(),       64'd0);
        chk({tag, " busy"},  64'(idu_busy),    64'd0);
        chk({tag, " done"},  64'(idu_done),    64'd0);
        chk({tag, " err"},   64'(idu_err),     64'd0);
    endtask

    initial begin
        logic [63:0] a, b, c, d, h, n, x;
        n_vec = 0;
        n_bad = 0;
        a = mkins(8'h02, 8'h01);
        b = mkins(8'h03, 8'h02);
        c = mkins(8'h04, 8'h03);
        d = mkins(8'h05, 8'h04);
        h = mkins(8'h00, 8'h0e);
        n = mkins(8'h01, 8'h0f);
        x = mkins(8'h20, 8'h11);

        // basic flow, execution unit always ready
        tbl.push_back(mkv(1, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mkv(0, 1, a, 1,  1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mkv(0, 1, b, 1,  1, 1, 1, a, 1, 0, 0));
        tbl.push_back(mkv(0, 1, h, 1,  1, 0, 1, b, 1, 0, 0));
        tbl.push_back(mkv(0, 0, 0, 1,  0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mkv(0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0));
        // backpressure, then simultaneous enqueue/dequeue across pointer wrap
        tbl.push_back(mkv(1, 1, a, 0,  0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mkv(0, 1, a, 0,  1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mkv(0, 1, b, 0,  1, 1, 1, a, 1, 0, 0));
        tbl.push_back(mkv(0, 1, c, 0,  0, 1, 1, a, 1, 0, 0));
        tbl.push_back(mkv(0, 1, c, 1,  0, 1, 1, a, 1, 0, 0));
        tbl.push_back(mkv(0, 1, c, 1,  1, 1, 1, b, 1, 0, 0));
        tbl.push_back(mkv(0, 1, d, 1,  1, 1, 1, c, 1, 0, 0));
        tbl.push_back(mkv(0, 1, h, 0,  1, 0, 1, d, 1, 0, 0));
        tbl.push_back(mkv(0, 0, 0, 0,  0, 0, 1, d, 1, 0, 0));
        tbl.push_back(mkv(0, 0, 0, 1,  0, 0, 1, d, 1, 0, 0));
        tbl.push_back(mkv(0, 0, 0, 1,  0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mkv(0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0));
        // NOP and illegal filtering, sticky err cleared by start_vld
        tbl.push_back(mkv(1, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mkv(0, 1, n, 1,  1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mkv(0, 1, x, 1,  1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mkv(0, 1, a, 1,  1, 1, 0, 0, 1, 0, 1));
        tbl.push_back(mkv(0, 0, 0, 1,  1, 1, 1, a, 1, 0, 1));
        tbl.push_back(mkv(0, 0, 0, 1,  1, 1, 0, 0, 1, 0, 1));
        tbl.push_back(mkv(1, 0, 0, 1,  1, 1, 0, 0, 1, 0, 1));
        tbl.push_back(mkv(0, 0, 0, 1,  1, 1, 0, 0, 1, 0, 0));
        // flush with a full queue in RUN, then flush from DRAIN
        tbl.push_back(mkv(0, 1, a, 0,  1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mkv(0, 1, b, 0,  1, 1, 1, a, 1, 0, 0));
        tbl.push_back(mkv(1, 0, 0, 0,  0, 1, 1, a, 1, 0, 0));
        tbl.push_back(mkv(0, 0, 0, 0,  1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mkv(0, 1, a, 0,  1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mkv(0, 1, h, 0,  1, 0, 1, a, 1, 0, 0));
        tbl.push_back(mkv(1, 0, 0, 0,  0, 0, 1, a, 1, 0, 0));
        tbl.push_back(mkv(0, 0, 0, 0,  1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mkv(0, 1, c, 0,  1, 1, 0, 0, 1, 0, 0));

        // reset
        rst         = 1'b1;
        start_vld   = 1'b0;
        ifu_idu_vld = 1'b0;
        ifu_idu_ins = '0;
        exu_idu_rdy = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_all_zero("reset");
        chk("reset state", 64'(dbg_state), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // table
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            start_vld   = tbl[i].st;
            ifu_idu_vld = tbl[i].vld;
            ifu_idu_ins = tbl[i].ins;
            exu_idu_rdy = tbl[i].xrdy;
            #1;
            n_vec++;
            chk($sformatf("v%0d rdy", i),  64'(idu_ifu_rdy), 64'(tbl[i].e_rdy));
            chk($sformatf("v%0d wfi", i),  64'(idu_ifu_wfi), 64'(tbl[i].e_wfi));
            chk($sformatf("v%0d xvld", i), 64'(idu_exu_vld), 64'(tbl[i].e_xvld));
            chk($sformatf("v%0d head", i), head_now(),       tbl[i].e_head);
            chk($sformatf("v%0d busy", i), 64'(idu_busy),    64'(tbl[i].e_busy));
            chk($sformatf("v%0d done", i), 64'(idu_done),    64'(tbl[i].e_done));
            chk($sformatf("v%0d err", i),  64'(idu_err),     64'(tbl[i].e_err));
        end

        // asynchronous reset mid-RUN with one entry (c) queued
        @(negedge clk);
        start_vld   = 1'b0;
        ifu_idu_vld = 1'b0;
        exu_idu_rdy = 1'b0;
        #1;
        n_vec++;
        chk("pre-rst xvld", 64'(idu_exu_vld), 64'd1);
        chk("pre-rst head", head_now(),       c);
        chk("pre-rst rdy",  64'(idu_ifu_rdy), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("async rst");
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++;
        chk("post-rst state", 64'(dbg_state), 64'd0);
        chk("post-rst busy",  64'(idu_busy),  64'd0);
        chk("post-rst xvld",  64'(idu_exu_vld), 64'd0);

        // restart after reset still dispatches
        @(negedge clk);
        start_vld = 1'b1;
        #1;
        @(negedge clk);
        start_vld   = 1'b0;
        ifu_idu_vld = 1'b1;
        ifu_idu_ins = d;
        #1;
        n_vec++;
        chk("restart rdy", 64'(idu_ifu_rdy), 64'd1);
        @(negedge clk);
        ifu_idu_vld = 1'b0;
        #1;
        n_vec++;
        chk("restart head", head_now(), d);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
